// File: rtl/led_bank_ctrl.sv
// Two-bank LED controller: per-channel off/on/blink/PWM modes, valid/ready config port, broadcast sweep.
// Optional LED_READBACK_EN adds a registered configuration readback port (rd_addr/rd_data).
module led_bank_ctrl #(
  parameter int unsigned LEDR_W       = 10,
  parameter int unsigned LEDG_W       = 10,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned TICK_DIV     = 500,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [PWM_W+1:0]    cfg_data,
`ifdef LED_READBACK_EN
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [PWM_W+1:0]    rd_data,
`endif
  output logic [LEDR_W-1:0]   LEDR,
  output logic [LEDG_W-1:0]   LEDG
);

  localparam int unsigned NCH    = LEDR_W + LEDG_W;
  localparam int unsigned CW     = PWM_W + 2;
  localparam int unsigned PH_MAX = (2 ** PWM_W) - 2;
  localparam int unsigned TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned IW     = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_PWM} mode_t;
  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ready_q, ready_d;
  logic [CW-1:0]     bdata_q, bdata_d;
  logic              pend_q, pend_d;
  logic [IW-1:0]     paddr_q, paddr_d;
  logic [CW-1:0]     pdata_q, pdata_d;
  logic [CW-1:0]     cfg_q [NCH];
  logic [CW-1:0]     cfg_d [NCH];
  logic [TW-1:0]     tick_q, tick_d;
  logic [PWM_W-1:0]  phase_q, phase_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              blink_q, blink_d;
  logic [NCH-1:0]    led_q, led_d;

  logic accept, step, frame_end, blink_wrap;

  // Handshake / sweep FSM; unicast writes are staged one cycle before hitting the channel file.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    bdata_d = bdata_q;
    pend_d  = 1'b0;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    accept  = cfg_valid && ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cfg_addr == '1) begin
            state_d = ST_SWEEP;
            ready_d = 1'b0;
            idx_d   = '0;
            bdata_d = cfg_data;
          end else if (cfg_addr < ADDR_W'(NCH)) begin
            pend_d  = 1'b1;
            paddr_d = IW'(cfg_addr);
            pdata_d = cfg_data;
          end
        end
      end
      ST_SWEEP: begin
        if (idx_q == IW'(NCH - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        idx_d   = '0;
      end
    endcase
  end

  // A staged unicast and a sweep write can never coincide: both start from an IDLE accept.
  always_comb begin
    cfg_d = cfg_q;
    if (pend_q) begin
      cfg_d[paddr_q] = pdata_q;
    end else if (state_q == ST_SWEEP) begin
      cfg_d[idx_q] = bdata_q;
    end
  end

  always_comb begin
    step       = (tick_q == TW'(TICK_DIV - 1));
    tick_d     = step ? '0 : tick_q + 1'b1;
    frame_end  = step && (phase_q == PWM_W'(PH_MAX));
    phase_d    = phase_q;
    if (step) phase_d = frame_end ? '0 : phase_q + 1'b1;
    blink_wrap = frame_end && (bcnt_q == BW'(BLINK_FRAMES - 1));
    bcnt_d     = bcnt_q;
    if (frame_end) bcnt_d = blink_wrap ? '0 : bcnt_q + 1'b1;
    blink_d    = blink_q ^ blink_wrap;
  end

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      case (mode_t'(cfg_q[i][CW-1:PWM_W]))
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = blink_q;
        MODE_PWM:   led_d[i] = (phase_q < cfg_q[i][PWM_W-1:0]);
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
      bdata_q <= '0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) cfg_q[i] <= '0;
      tick_q  <= '0;
      phase_q <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      bdata_q <= bdata_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      cfg_q   <= cfg_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign cfg_ready = ready_q;
  assign LEDR      = led_q[LEDR_W-1:0];
  assign LEDG      = led_q[NCH-1:LEDR_W];

`ifdef LED_READBACK_EN
  logic [CW-1:0] rd_q, rd_d;

  // Reads the current file, so a same-cycle write to the same channel returns the old value.
  always_comb begin
    rd_d = '0;
    if (rd_addr < ADDR_W'(NCH)) rd_d = cfg_q[IW'(rd_addr)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data = rd_q;
`endif

endmodule
